// File: rtl/apb_master_n.sv
// APB master bridge: decodes a CPU request onto one of NUM_SLAVES completers; 2 cycles + wait states per access, 1 for unmapped.
// Single outstanding request; transfer is only sampled in IDLE, PREADY stalls ACCESS up to TIMEOUT cycles.
module apb_master_n #(
  parameter int          NUM_SLAVES = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          SLOT_BITS  = 12,
  parameter int          TIMEOUT    = 16
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     transfer,
  input  logic                     write,
  input  logic [31:0]              addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata,
  output logic                     ready,
  output logic                     err,
  output logic [31:0]              PADDR,
  output logic                     PWRITE,
  output logic                     PENABLE,
  output logic [31:0]              PWDATA,
  output logic [NUM_SLAVES-1:0]    PSEL,
  input  logic [32*NUM_SLAVES-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]    PREADY,
  input  logic [NUM_SLAVES-1:0]    PSLVERR
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_ERR} state_t;

  state_t                  state_q;
  logic [31:0]             paddr_q;
  logic                    pwrite_q;
  logic [31:0]             pwdata_q;
  logic [7:0]              cnt_q;

  logic [31:0]             slot_idx;
  logic [NUM_SLAVES-1:0]   sel_oh;
  logic                    sel_ready;
  logic                    sel_err;
  logic [31:0]             sel_rdata;
  logic                    timeout_hit;

  function automatic logic in_window(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ((off >> SLOT_BITS) < 32'(NUM_SLAVES));
  endfunction

  assign slot_idx = (paddr_q - BASE_ADDR) >> SLOT_BITS;

  // The address guard matters when BASE_ADDR is high and a low address wraps into a valid slot number.
  always_comb begin
    sel_oh    = '0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel_oh[i] = (paddr_q >= BASE_ADDR) && (slot_idx == 32'(i));
      if (sel_oh[i]) begin
        sel_rdata = sel_rdata | PRDATA[32*i +: 32];
      end
    end
  end

  assign sel_ready   = |(PREADY & sel_oh);
  assign sel_err     = |(PSLVERR & sel_oh);
  assign timeout_hit = (cnt_q == CNT_LAST);

  always_comb begin
    PSEL    = '0;
    PENABLE = 1'b0;
    ready   = 1'b0;
    err     = 1'b0;
    rdata   = '0;
    case (state_q)
      S_SETUP: PSEL = sel_oh;
      S_ACCESS: begin
        PSEL    = sel_oh;
        PENABLE = 1'b1;
        if (sel_ready) begin
          ready = 1'b1;
          err   = sel_err;
          rdata = pwrite_q ? 32'h0 : sel_rdata;
        end else if (timeout_hit) begin
          ready = 1'b1;
          err   = 1'b1;
        end
      end
      S_ERR: begin
        ready = 1'b1;
        err   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q  <= S_IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (transfer) begin
            paddr_q  <= addr;
            pwrite_q <= write;
            pwdata_q <= wdata;
            state_q  <= in_window(addr) ? S_SETUP : S_ERR;
          end
        end
        S_SETUP: begin
          cnt_q   <= '0;
          state_q <= S_ACCESS;
        end
        S_ACCESS: begin
          if (sel_ready || timeout_hit) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_ERR:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign PADDR  = paddr_q;
  assign PWRITE = pwrite_q;
  assign PWDATA = pwdata_q;

endmodule

// File: tb/tb_apb_master_n.sv
// Bench for apb_master_n: modelled APB completers, queue-based scoreboard, directed then random requests.
module tb_apb_master_n;
  localparam int          N    = 8;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          TO   = 16;
  localparam int          WIN  = 4096;

  logic              PCLK = 1'b0;
  logic              PRESET;
  logic              transfer;
  logic              write;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ready;
  logic              err;
  logic [31:0]       PADDR;
  logic              PWRITE;
  logic              PENABLE;
  logic [31:0]       PWDATA;
  logic [N-1:0]      PSEL;
  logic [32*N-1:0]   PRDATA;
  logic [N-1:0]      PREADY;
  logic [N-1:0]      PSLVERR;

  apb_master_n #(.NUM_SLAVES(N), .BASE_ADDR(BASE), .SLOT_BITS(12), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .write(write), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ready(ready), .err(err), .PADDR(PADDR),
    .PWRITE(PWRITE), .PENABLE(PENABLE), .PWDATA(PWDATA), .PSEL(PSEL),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic         err;
    logic [31:0]  rdata;
    int           lat;
    int           pen;
    int           sel;
    logic [N-1:0] psel;
    logic [31:0]  paddr;
    logic         pwrite;
    logic [31:0]  pwdata;
    int           issue;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Completer model: slave i answers after ws[i] wait states (>= TO means it never answers).
  int           ws[N];
  logic         serr[N];
  logic [31:0]  mem[N];
  logic [2*N-1:0] noise = '0;
  int acc_cnt = 0;
  int acc_nxt = 0;

  always @(posedge PCLK) cyc <= cyc + 1;
  always @(posedge PCLK) noise <= 16'($urandom);
  always @(negedge PCLK) acc_nxt = (PENABLE === 1'b1 && ready !== 1'b1) ? acc_cnt + 1 : 0;
  always @(posedge PCLK) acc_cnt <= acc_nxt;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      PRDATA[32*i +: 32] = mem[i];
      PREADY[i]  = PSEL[i] ? (acc_cnt >= ws[i]) : noise[i];
      PSLVERR[i] = PSEL[i] ? serr[i] : noise[N+i];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic w, input logic [31:0] a, input logic [31:0] d, input int at);
    exp_t e;
    longint off;
    int s;
    e.paddr  = a;
    e.pwrite = w;
    e.pwdata = d;
    e.issue  = at;
    e.psel   = '0;
    e.err    = 1'b1;
    e.rdata  = 32'h0;
    e.lat    = 1;
    e.pen    = 0;
    e.sel    = 0;
    off = longint'({32'b0, a}) - longint'({32'b0, BASE});
    if (off >= 0 && off / WIN < N) begin
      s = int'(off / WIN);
      e.psel[s] = 1'b1;
      if (ws[s] >= TO) begin
        e.pen = TO;
        e.lat = TO + 1;
      end else begin
        e.err   = serr[s];
        e.rdata = w ? 32'h0 : mem[s];
        e.pen   = ws[s] + 1;
        e.lat   = ws[s] + 2;
      end
      e.sel = e.pen + 1;
    end
    return e;
  endfunction

  // Monitor: counts APB activity for the outstanding request and scores each ready pulse.
  int pen_cnt = 0;
  int sel_cnt = 0;
  always @(negedge PCLK) begin
    exp_t e;
    if (q.size() == 0) begin
      pen_cnt = 0;
      sel_cnt = 0;
      if (ready === 1'b1) begin
        tests++;
        fails++;
        $display("FAIL spurious_ready: got ready=1 with no request outstanding (t=%0t)", $time);
      end
    end else begin
      if (PSEL != '0) sel_cnt++;
      if (PENABLE === 1'b1) pen_cnt++;
      if (ready === 1'b1) begin
        e = q.pop_front();
        check("err", {31'b0, err}, {31'b0, e.err});
        check("rdata", rdata, e.rdata);
        check("latency", 32'(cyc - e.issue), 32'(e.lat));
        check("penable_cycles", 32'(pen_cnt), 32'(e.pen));
        check("psel_cycles", 32'(sel_cnt), 32'(e.sel));
        check("psel", 32'(PSEL), 32'(e.psel));
        check("paddr", PADDR, e.paddr);
        check("pwrite", {31'b0, PWRITE}, {31'b0, e.pwrite});
        check("pwdata", PWDATA, e.pwdata);
        pen_cnt = 0;
        sel_cnt = 0;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 400) begin
      @(negedge PCLK);
      n++;
    end
    check("ready_wait", {31'b0, n < 400}, 32'h1);
    @(negedge PCLK);
  endtask

  // Called at a negedge with the DUT idle; scrambles the CPU inputs after the sampling edge.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    q.push_back(model(w, a, d, cyc));
    transfer = 1'b1;
    write    = w;
    addr     = a;
    wdata    = d;
    @(negedge PCLK);
    transfer = 1'b0;
    write    = 1'($urandom);
    addr     = $urandom;
    wdata    = $urandom;
    wait_ready();
  endtask

  task automatic randomize_slaves();
    int opts[7] = '{0, 1, 2, 3, 15, 16, 255};
    for (int i = 0; i < N; i++) begin
      mem[i]  = $urandom;
      serr[i] = 1'($urandom_range(0, 1));
      ws[i]   = opts[$urandom_range(0, 6)];
    end
  endtask

  initial begin
    logic [31:0] a;
    for (int i = 0; i < N; i++) begin
      ws[i]   = 0;
      serr[i] = 1'b0;
      mem[i]  = $urandom;
    end
    PRESET   = 1'b1;
    transfer = 1'b0;
    write    = 1'b0;
    addr     = '0;
    wdata    = '0;
    repeat (3) @(negedge PCLK);
    check("rst_ready", {31'b0, ready}, 32'h0);
    check("rst_err", {31'b0, err}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_psel", 32'(PSEL), 32'h0);
    check("rst_penable", {31'b0, PENABLE}, 32'h0);
    check("rst_paddr", PADDR, 32'h0);
    check("rst_pwrite", {31'b0, PWRITE}, 32'h0);
    check("rst_pwdata", PWDATA, 32'h0);
    PRESET = 1'b0;
    @(negedge PCLK);

    // Zero-wait read from slave 2
    mem[2] = 32'hCAFE_0001;
    issue(1'b0, 32'h1000_2004, 32'h0);
    // Write to slave 1 with 3 wait states
    ws[1] = 3;
    issue(1'b1, 32'h1000_1000, 32'h0000_00A5);
    // Unmapped: one slot past the end, and just below the base
    issue(1'b0, 32'h1000_8000, 32'h0);
    issue(1'b1, 32'h0FFF_FFFC, 32'h1234_5678);
    // Stuck slave 3 times out, then slave 0 works normally
    ws[3] = 255;
    issue(1'b0, 32'h1000_3000, 32'h0);
    ws[0] = 0;
    issue(1'b0, 32'h1000_0010, 32'h0);
    // Last wait state before the timeout, and exactly at it
    ws[4] = TO - 1;
    issue(1'b0, 32'h1000_4008, 32'h0);
    ws[4] = TO;
    issue(1'b0, 32'h1000_4008, 32'h0);
    // PSLVERR forwarding on slave 5
    serr[5] = 1'b1;
    issue(1'b0, 32'h1000_5000, 32'h0);
    serr[5] = 1'b0;
    issue(1'b0, 32'h1000_5000, 32'h0);

    // Reset during a wait state, with transfer held high across the release
    ws[3]    = 255;
    transfer = 1'b1;
    write    = 1'b0;
    addr     = 32'h1000_3000;
    @(negedge PCLK);
    transfer = 1'b0;
    repeat (2) @(negedge PCLK);
    PRESET   = 1'b1;
    transfer = 1'b1;
    addr     = 32'h1000_0020;
    write    = 1'b0;
    @(negedge PCLK);
    check("rstmid_psel", 32'(PSEL), 32'h0);
    check("rstmid_penable", {31'b0, PENABLE}, 32'h0);
    check("rstmid_ready", {31'b0, ready}, 32'h0);
    q.push_back(model(1'b0, 32'h1000_0020, wdata, cyc));
    PRESET = 1'b0;
    @(negedge PCLK);
    transfer = 1'b0;
    addr     = $urandom;
    wait_ready();

    for (int t = 0; t < 60; t++) begin
      randomize_slaves();
      a = BASE - 32'h100 + 32'($urandom_range(0, 32'h9200));
      a[1:0] = 2'b00;
      issue(1'($urandom), a, $urandom);
    end

    repeat (3) @(negedge PCLK);
    check("queue_drained", 32'(q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/apb_master_n.md
Name: apb_master_n

Overview:
- Parametrised APB master bridge between the RV32I CPU data bus and N APB completer peripherals (RAM, GPO, GPI, GPIO, UART, ...).
- Replaces the fixed 4-slave master and adds:
  - a parametric address decoder;
  - request latching;
  - a PREADY timeout;
  - PSLVERR forwarding;
  - a bus-error output for unmapped or failed accesses.

Parameters:
- NUM_SLAVES, 8: number of APB completers; legal range 1..16.
- BASE_ADDR, 32'h1000_0000: address of slot 0; must be aligned to 2**SLOT_BITS.
- SLOT_BITS, 12: log2 of the window size per slave (4 KB by default).
- TIMEOUT, 16: maximum number of ACCESS cycles waiting for PREADY; legal range 2..255.

Ports:
- PCLK, input, 1: clock.
- PRESET, input, 1: synchronous, active-high reset.
- transfer, input, 1: CPU request strobe; sampled only in IDLE.
- write, input, 1: 1 = write, 0 = read.
- addr, input, 32: CPU byte address.
- wdata, input, 32: CPU write data.
- rdata, output, 32: read data; valid only while ready=1.
- ready, output, 1: transfer-complete pulse, one cycle wide.
- err, output, 1: bus error; qualified by ready.
- PADDR, output, 32: APB address.
- PWRITE, output, 1: APB direction.
- PENABLE, output, 1: APB enable.
- PWDATA, output, 32: APB write data.
- PSEL, output, NUM_SLAVES: one-hot completer select.
- PRDATA, input, 32*NUM_SLAVES: flattened completer read data; slave i occupies bits [32*i+31:32*i].
- PREADY, input, NUM_SLAVES: per-completer ready.
- PSLVERR, input, NUM_SLAVES: per-completer error.

Behaviour:
- One clock domain (PCLK). PRESET is synchronous and active-high; it is sampled at the PCLK edge and overrides every other input.
- Reset state:
  - State = IDLE.
  - PSEL = 0, PENABLE = 0, PADDR = 0, PWRITE = 0, PWDATA = 0.
  - ready = 0, err = 0, rdata = 0, timeout counter = 0.
- Decode:
  - slot = (addr - BASE_ADDR) >> SLOT_BITS.
  - The access is mapped when addr >= BASE_ADDR and slot < NUM_SLAVES.
  - Decode is evaluated on the latched address.
- FSM states:
  - IDLE:
    - On transfer=1, latch addr, write and wdata into PADDR, PWRITE and PWDATA.
    - Go to SETUP if mapped, else go to ERR.
    - transfer=0: stay in IDLE.
  - SETUP:
    - PSEL[slot]=1, PENABLE=0.
    - Go unconditionally to ACCESS; clear the counter.
  - ACCESS:
    - PSEL[slot]=1, PENABLE=1.
    - If PREADY[slot]=1:
      - ready=1, err=PSLVERR[slot].
      - rdata = PRDATA slice for slot (0 when PWRITE=1).
      - Go to IDLE.
    - Else increment the counter.
    - When the counter reaches TIMEOUT-1 with PREADY still 0:
      - ready=1, err=1, rdata=0.
      - Go to IDLE; the APB transfer is abandoned with PSEL and PENABLE dropped on the next cycle.
  - ERR:
    - ready=1, err=1, rdata=0, no PSEL asserted.
    - Go to IDLE.
- Outputs are combinational from the state and latched registers:
  - ready, err and rdata are combinational in ACCESS.
  - PSEL and PENABLE are decoded from the state.
- Latency:
  - Zero-wait-state completer: transfer sampled at edge N; SETUP in cycle N+1; ACCESS with ready=1 in cycle N+2.
  - Each wait state adds one cycle.
  - Unmapped access: ready=1 in cycle N+1.
- PADDR, PWRITE and PWDATA are held stable from SETUP through the end of ACCESS. The CPU may change addr, wdata and write after the sampling edge.
- transfer asserted outside IDLE is ignored, not queued. The next request is accepted in the cycle after ready, once back in IDLE.
- PREADY, PSLVERR and PRDATA of unselected slots are ignored. PSEL is never multi-hot.
- PSLVERR is sampled only in the cycle where PREADY=1 in ACCESS.
- Reset during SETUP or ACCESS: return to IDLE with no ready pulse and all APB outputs cleared at that edge.

Test Plan:
- Zero-wait read: write=0, addr=32'h1000_2004, slave 2 PREADY=1, PRDATA=32'hCAFE_0001 -> PSEL=8'b0000_0100, PADDR=32'h1000_2004; ready=1, err=0, rdata=32'hCAFE_0001 two cycles after transfer.
- Write with 3 wait states: addr=32'h1000_1000, wdata=32'h0000_00A5 to slave 1 -> PWRITE=1, PWDATA=32'h0000_00A5, PENABLE held high 4 cycles; ready on cycle 5 after transfer; CPU addr changed mid-transfer does not alter PADDR.
- Unmapped accesses: addr=32'h1000_8000 (slot 8) and addr=32'h0FFF_FFFC -> no PSEL pulse, ready=1, err=1, rdata=0, one cycle after transfer.
- Timeout: slave 3 PREADY stuck at 0 with TIMEOUT=16 -> exactly 16 ACCESS cycles, then ready=1, err=1, rdata=0; back in IDLE and a following read to slave 0 completes normally.
- PSLVERR: slave 5 returns PREADY=1 with PSLVERR=1 -> ready=1, err=1; a repeat with PSLVERR=0 gives err=0.
- Reset mid-ACCESS: assert PRESET during a wait state -> next cycle PSEL=0, PENABLE=0, ready=0, state IDLE; transfer held high across reset release is accepted in the first cycle after release.
